// File: rtl/difftest_debugmode_source.sv
// Debug-mode state producer for difftest: dcsr/dpc/dscratch CSRs, RUN/DEBUG/EXIT entry FSM and a
// snapshot FIFO toward the DPI sink. Define DIFFTEST_DEBUGMODE_SNAPSHOT_EN to build the snapshot path.
module difftest_debugmode_source #(
  parameter int         DEPTH     = 4,
  parameter logic [3:0] XDEBUGVER = 4'd4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_haltReq,
  input  logic        io_ebreak,
  input  logic        io_stepDone,
  input  logic [63:0] io_pc,
  input  logic [1:0]  io_priv,
  input  logic        io_dret,
  input  logic        io_csrWen,
  input  logic [11:0] io_csrAddr,
  input  logic [63:0] io_csrWdata,
  input  logic [7:0]  io_coreid,
  output logic        io_debugMode,
  output logic [63:0] io_dcsr,
  output logic [63:0] io_dpc,
  output logic [63:0] io_dscratch0,
  output logic [63:0] io_dscratch1,
  output logic        io_redirectValid,
  output logic [63:0] io_redirectPc,
  output logic        io_diffValid,
  input  logic        io_diffReady,
  output logic        io_diff_debugMode,
  output logic [63:0] io_diff_dcsr,
  output logic [63:0] io_diff_dpc,
  output logic [63:0] io_diff_dscratch0,
  output logic [63:0] io_diff_dscratch1,
  output logic [7:0]  io_diff_coreid,
  output logic        io_overflow
);

  localparam logic [11:0] ADDR_DCSR      = 12'h7B0;
  localparam logic [11:0] ADDR_DPC       = 12'h7B1;
  localparam logic [11:0] ADDR_DSCRATCH0 = 12'h7B2;
  localparam logic [11:0] ADDR_DSCRATCH1 = 12'h7B3;

  typedef enum logic [1:0] {ST_RUN, ST_DEBUG, ST_EXIT} state_e;
  typedef enum logic [2:0] {
    CAUSE_NONE    = 3'd0,
    CAUSE_EBREAK  = 3'd1,
    CAUSE_HALTREQ = 3'd3,
    CAUSE_STEP    = 3'd4
  } cause_e;

  state_e      state_q, state_d;
  logic        ebreakm_q, ebreakm_d;
  logic        ebreaks_q, ebreaks_d;
  logic        ebreaku_q, ebreaku_d;
  logic        step_q, step_d;
  logic [1:0]  prv_q, prv_d;
  logic [2:0]  cause_q, cause_d;
  logic [63:0] dpc_q, dpc_d;
  logic [63:0] dscratch0_q, dscratch0_d;
  logic [63:0] dscratch1_q, dscratch1_d;
  logic        ebreak_enabled;
  cause_e      entry_cause;

  // Each privilege level has its own ebreak-to-debug enable; priv 2 is reserved and never enters.
  always_comb begin
    case (io_priv)
      2'd3:    ebreak_enabled = ebreakm_q;
      2'd1:    ebreak_enabled = ebreaks_q;
      2'd0:    ebreak_enabled = ebreaku_q;
      default: ebreak_enabled = 1'b0;
    endcase
  end

  always_comb begin
    if (io_ebreak && ebreak_enabled)  entry_cause = CAUSE_EBREAK;
    else if (io_haltReq)              entry_cause = CAUSE_HALTREQ;
    else if (io_stepDone && step_q)   entry_cause = CAUSE_STEP;
    else                              entry_cause = CAUSE_NONE;
  end

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through the case can infer a latch.
    state_d     = state_q;
    ebreakm_d   = ebreakm_q;
    ebreaks_d   = ebreaks_q;
    ebreaku_d   = ebreaku_q;
    step_d      = step_q;
    prv_d       = prv_q;
    cause_d     = cause_q;
    dpc_d       = dpc_q;
    dscratch0_d = dscratch0_q;
    dscratch1_d = dscratch1_q;
    case (state_q)
      ST_RUN: begin
        if (entry_cause != CAUSE_NONE) begin
          state_d = ST_DEBUG;
          dpc_d   = io_pc;
          prv_d   = io_priv;
          cause_d = entry_cause;
        end
      end
      ST_DEBUG: begin
        // dret takes priority; a CSR write in the same cycle is dropped.
        if (io_dret) begin
          state_d = ST_EXIT;
        end else if (io_csrWen) begin
          case (io_csrAddr)
            ADDR_DCSR: begin
              ebreakm_d = io_csrWdata[15];
              ebreaks_d = io_csrWdata[13];
              ebreaku_d = io_csrWdata[12];
              step_d    = io_csrWdata[2];
              prv_d     = io_csrWdata[1:0];
            end
            ADDR_DPC:       dpc_d       = {io_csrWdata[63:1], 1'b0};
            ADDR_DSCRATCH0: dscratch0_d = io_csrWdata;
            ADDR_DSCRATCH1: dscratch1_d = io_csrWdata;
            default: ;
          endcase
        end
      end
      ST_EXIT: state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_RUN;
      ebreakm_q   <= 1'b0;
      ebreaks_q   <= 1'b0;
      ebreaku_q   <= 1'b0;
      step_q      <= 1'b0;
      prv_q       <= 2'd3;
      cause_q     <= 3'd0;
      dpc_q       <= '0;
      dscratch0_q <= '0;
      dscratch1_q <= '0;
    end else begin
      state_q     <= state_d;
      ebreakm_q   <= ebreakm_d;
      ebreaks_q   <= ebreaks_d;
      ebreaku_q   <= ebreaku_d;
      step_q      <= step_d;
      prv_q       <= prv_d;
      cause_q     <= cause_d;
      dpc_q       <= dpc_d;
      dscratch0_q <= dscratch0_d;
      dscratch1_q <= dscratch1_d;
    end
  end

  assign io_debugMode     = (state_q == ST_DEBUG);
  assign io_dcsr          = {32'h0, XDEBUGVER, 12'h0, ebreakm_q, 1'b0, ebreaks_q, ebreaku_q,
                             3'b000, cause_q, 3'b000, step_q, prv_q};
  assign io_dpc           = dpc_q;
  assign io_dscratch0     = dscratch0_q;
  assign io_dscratch1     = dscratch1_q;
  assign io_redirectValid = (state_q == ST_EXIT);
  assign io_redirectPc    = dpc_q;

`ifdef DIFFTEST_DEBUGMODE_SNAPSHOT_EN
  typedef struct packed {
    logic        debug_mode;
    logic [63:0] dcsr;
    logic [63:0] dpc;
    logic [63:0] dscratch0;
    logic [63:0] dscratch1;
  } tuple_t;

  typedef struct packed {
    tuple_t      tuple;
    logic [7:0]  coreid;
  } record_t;

  localparam int             PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);
  localparam tuple_t         RESET_TUPLE = '{
    debug_mode: 1'b0,
    dcsr:       {32'h0, XDEBUGVER, 26'h0, 2'b11},
    dpc:        64'h0,
    dscratch0:  64'h0,
    dscratch1:  64'h0
  };

  tuple_t           cur_tuple, last_q;
  record_t          mem [DEPTH];
  record_t          head;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             overflow_q;
  logic             changed, full, empty, do_pop, do_push, drop;

  assign cur_tuple = '{
    debug_mode: io_debugMode,
    dcsr:       io_dcsr,
    dpc:        dpc_q,
    dscratch0:  dscratch0_q,
    dscratch1:  dscratch1_q
  };

  assign changed = (cur_tuple != last_q);
  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_COUNT);
  assign do_pop  = !empty && io_diffReady;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign do_push = changed && (!full || do_pop);
  assign drop    = changed && full && !do_pop;

  always_ff @(posedge clock) begin
    if (reset) begin
      last_q     <= RESET_TUPLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (changed) last_q <= cur_tuple;
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
        default: count_q <= count_q;
      endcase
      if (drop) overflow_q <= 1'b1;
    end
  end

  // NOTE: the storage array is not reset; only pointers and count need a known value.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr_q] <= '{tuple: cur_tuple, coreid: io_coreid};
  end

  assign head              = mem[rd_ptr_q];
  assign io_diffValid      = !empty;
  assign io_diff_debugMode = head.tuple.debug_mode;
  assign io_diff_dcsr      = head.tuple.dcsr;
  assign io_diff_dpc       = head.tuple.dpc;
  assign io_diff_dscratch0 = head.tuple.dscratch0;
  assign io_diff_dscratch1 = head.tuple.dscratch1;
  assign io_diff_coreid    = head.coreid;
  assign io_overflow       = overflow_q;
`else
  logic unused_snapshot_inputs;
  assign unused_snapshot_inputs = ^{io_diffReady, io_coreid};

  assign io_diffValid      = 1'b0;
  assign io_diff_debugMode = 1'b0;
  assign io_diff_dcsr      = '0;
  assign io_diff_dpc       = '0;
  assign io_diff_dscratch0 = '0;
  assign io_diff_dscratch1 = '0;
  assign io_diff_coreid    = '0;
  assign io_overflow       = 1'b0;
`endif

endmodule

// File: tb/tb_difftest_debugmode_source.sv
// Scoreboard bench for difftest_debugmode_source: directed scenarios plus random traffic against a
// mask-based architectural model; snapshot records are queued by the model and popped by a monitor.
module tb_difftest_debugmode_source;

  localparam int DEPTH = 4;
`ifdef DIFFTEST_DEBUGMODE_SNAPSHOT_EN
  localparam bit SNAP_EN = 1'b1;
`else
  localparam bit SNAP_EN = 1'b0;
`endif

  localparam logic [63:0] DCSR_RST   = 64'h4000_0003;
  localparam logic [63:0] DCSR_WMASK = 64'h0000_B007;
  localparam logic [63:0] ENTRY_MASK = 64'h0000_01C3;
  localparam int M_RUN = 0, M_DBG = 1, M_EXIT = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_haltReq, io_ebreak, io_stepDone, io_dret, io_csrWen, io_diffReady;
  logic [63:0] io_pc, io_csrWdata;
  logic [1:0]  io_priv;
  logic [11:0] io_csrAddr;
  logic [7:0]  io_coreid;
  logic        io_debugMode, io_redirectValid, io_diffValid, io_diff_debugMode, io_overflow;
  logic [63:0] io_dcsr, io_dpc, io_dscratch0, io_dscratch1, io_redirectPc;
  logic [63:0] io_diff_dcsr, io_diff_dpc, io_diff_dscratch0, io_diff_dscratch1;
  logic [7:0]  io_diff_coreid;

  difftest_debugmode_source #(.DEPTH(DEPTH), .XDEBUGVER(4'd4)) dut (
    .clock(clock), .reset(reset),
    .io_haltReq(io_haltReq), .io_ebreak(io_ebreak), .io_stepDone(io_stepDone),
    .io_pc(io_pc), .io_priv(io_priv), .io_dret(io_dret),
    .io_csrWen(io_csrWen), .io_csrAddr(io_csrAddr), .io_csrWdata(io_csrWdata),
    .io_coreid(io_coreid),
    .io_debugMode(io_debugMode), .io_dcsr(io_dcsr), .io_dpc(io_dpc),
    .io_dscratch0(io_dscratch0), .io_dscratch1(io_dscratch1),
    .io_redirectValid(io_redirectValid), .io_redirectPc(io_redirectPc),
    .io_diffValid(io_diffValid), .io_diffReady(io_diffReady),
    .io_diff_debugMode(io_diff_debugMode), .io_diff_dcsr(io_diff_dcsr),
    .io_diff_dpc(io_diff_dpc), .io_diff_dscratch0(io_diff_dscratch0),
    .io_diff_dscratch1(io_diff_dscratch1), .io_diff_coreid(io_diff_coreid),
    .io_overflow(io_overflow)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: dcsr kept as a plain 64-bit word edited with masks.
  typedef struct {
    logic        dm;
    logic [63:0] dcsr, dpc, ds0, ds1;
    logic [7:0]  coreid;
  } rec_t;

  rec_t         exp_q[$];
  int           m_mode, occ, cause;
  logic [63:0]  m_dcsr, m_dpc, m_ds0, m_ds1;
  logic         m_ovf, en;
  logic [256:0] m_cur, m_last;

  always @(posedge clock) begin
    if (reset) begin
      m_mode = M_RUN; m_dcsr = DCSR_RST; m_dpc = '0; m_ds0 = '0; m_ds1 = '0;
      m_ovf = 1'b0; occ = 0; exp_q.delete();
      m_last = {1'b0, DCSR_RST, 192'h0};
    end else begin
      if (SNAP_EN) begin
        m_cur = {m_mode == M_DBG, m_dcsr, m_dpc, m_ds0, m_ds1};
        if (occ > 0 && io_diffReady) occ--;
        if (m_cur != m_last) begin
          m_last = m_cur;
          if (occ < DEPTH) begin
            exp_q.push_back('{dm: m_mode == M_DBG, dcsr: m_dcsr, dpc: m_dpc, ds0: m_ds0,
                              ds1: m_ds1, coreid: io_coreid});
            occ++;
          end else m_ovf = 1'b1;
        end
      end
      case (m_mode)
        M_RUN: begin
          en = (io_priv == 2'd3 && m_dcsr[15]) || (io_priv == 2'd1 && m_dcsr[13]) ||
               (io_priv == 2'd0 && m_dcsr[12]);
          if (io_ebreak && en)                 cause = 1;
          else if (io_haltReq)                 cause = 3;
          else if (io_stepDone && m_dcsr[2])   cause = 4;
          else                                 cause = 0;
          if (cause != 0) begin
            m_mode = M_DBG;
            m_dpc  = io_pc;
            m_dcsr = (m_dcsr & ~ENTRY_MASK) | (64'(cause) << 6) | 64'(io_priv);
          end
        end
        M_DBG: begin
          if (io_dret) m_mode = M_EXIT;
          else if (io_csrWen) begin
            case (io_csrAddr)
              12'h7B0: m_dcsr = (m_dcsr & ~DCSR_WMASK) | (io_csrWdata & DCSR_WMASK);
              12'h7B1: m_dpc  = io_csrWdata & ~64'h1;
              12'h7B2: m_ds0  = io_csrWdata;
              12'h7B3: m_ds1  = io_csrWdata;
              default: ;
            endcase
          end
        end
        default: m_mode = M_RUN;
      endcase
    end
  end

  // Monitor: live state against the model, FIFO head against the scoreboard queue.
  rec_t h;
  always @(negedge clock) begin
    if (mon_en) begin
      check("debugMode", io_debugMode, m_mode == M_DBG);
      check("dcsr", io_dcsr, m_dcsr);
      check("dpc", io_dpc, m_dpc);
      check("dscratch0", io_dscratch0, m_ds0);
      check("dscratch1", io_dscratch1, m_ds1);
      check("redirectValid", io_redirectValid, m_mode == M_EXIT);
      if (m_mode == M_EXIT) check("redirectPc", io_redirectPc, m_dpc);
      check("overflow", io_overflow, m_ovf);
      check("diffValid", io_diffValid, exp_q.size() != 0);
      if (io_diffValid && exp_q.size() != 0) begin
        h = exp_q[0];
        check("diff_debugMode", io_diff_debugMode, h.dm);
        check("diff_dcsr", io_diff_dcsr, h.dcsr);
        check("diff_dpc", io_diff_dpc, h.dpc);
        check("diff_dscratch0", io_diff_dscratch0, h.ds0);
        check("diff_dscratch1", io_diff_dscratch1, h.ds1);
        check("diff_coreid", io_diff_coreid, h.coreid);
        if (io_diffReady) h = exp_q.pop_front();
      end
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    io_haltReq = 0; io_ebreak = 0; io_stepDone = 0; io_dret = 0; io_csrWen = 0;
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [63:0] data);
    io_csrWen = 1; io_csrAddr = addr; io_csrWdata = data;
  endtask

  initial begin
    reset = 1; idle_inputs();
    io_pc = '0; io_priv = 2'd3; io_csrAddr = '0; io_csrWdata = '0;
    io_coreid = 8'h5A; io_diffReady = 0;

    // Reset held for 5 cycles
    next_cycle();
    mon_en = 1'b1;
    repeat (4) next_cycle();
    check("rst_dcsr", io_dcsr, 64'h4000_0003);
    check("rst_debugMode", io_debugMode, 0);
    check("rst_diffValid", io_diffValid, 0);
    reset = 0;
    next_cycle();

    // Halt request entry from U-mode
    io_haltReq = 1; io_pc = 64'h8000_1000; io_priv = 2'd0;
    next_cycle();
    io_haltReq = 0;
    check("halt_debugMode", io_debugMode, 1);
    check("halt_dpc", io_dpc, 64'h8000_1000);
    check("halt_cause", io_dcsr[8:6], 64'd3);
    check("halt_prv", io_dcsr[1:0], 64'd0);
    next_cycle();
    check("halt_snap_valid", io_diffValid, SNAP_EN);
    check("halt_snap_dm", io_diff_debugMode, SNAP_EN);
    check("halt_snap_dpc", io_diff_dpc, SNAP_EN ? 64'h8000_1000 : 64'h0);
    io_diffReady = 1;

    // dcsr all-ones write: only writable bits change, cause=3 retained
    csr_write(12'h7B0, '1);
    next_cycle();
    io_csrWen = 0;
    check("dcsr_ones", io_dcsr, 64'h4000_B007 | (64'd3 << 6));
    csr_write(12'h7B1, 64'h8000_1003);
    next_cycle();
    io_csrWen = 0;
    check("dpc_bit0", io_dpc, 64'h8000_1002);
    io_dret = 1;
    next_cycle();
    io_dret = 0;
    check("dret_redirect", io_redirectValid, 1);
    check("dret_pc", io_redirectPc, 64'h8000_1002);
    check("dret_dm", io_debugMode, 0);
    io_haltReq = 1;  // during EXIT: must be ignored
    next_cycle();
    io_haltReq = 0;
    check("exit_ignore_halt", io_debugMode, 0);
    check("redirect_pulse", io_redirectValid, 0);
    csr_write(12'h7B3, 64'hDEAD);  // RUN: write ignored
    next_cycle();
    io_csrWen = 0;
    check("run_write_ignored", io_dscratch1, 64'h0);

    // ebreak beats haltReq
    io_ebreak = 1; io_haltReq = 1; io_priv = 2'd3; io_pc = 64'h8000_2000;
    next_cycle();
    idle_inputs();
    check("ebreak_cause", io_dcsr[8:6], 64'd1);
    check("ebreak_prv", io_dcsr[1:0], 64'd3);
    check("ebreak_dpc", io_dpc, 64'h8000_2000);

    // dret wins over a same-cycle dpc write
    io_dret = 1; csr_write(12'h7B1, 64'h0);
    next_cycle();
    idle_inputs();
    check("dret_wins_valid", io_redirectValid, 1);
    check("dret_wins_pc", io_redirectPc, 64'h8000_2000);
    check("dret_wins_dpc", io_dpc, 64'h8000_2000);
    next_cycle();
    check("dret_wins_pulse", io_redirectValid, 0);

    // Overflow: DEPTH+1 snapshots with the sink stalled
    repeat (3) next_cycle();
    check("pre_ovf_empty", io_diffValid, 0);
    io_diffReady = 0;
    io_haltReq = 1; io_priv = 2'd0; io_pc = 64'h8000_3000;
    next_cycle();
    io_haltReq = 0;
    for (int i = 0; i < DEPTH; i++) begin
      csr_write(12'h7B2, 64'h11 + 64'(i));
      next_cycle();
    end
    io_csrWen = 0;
    next_cycle();
    check("ovf_flag", io_overflow, SNAP_EN);
    check("ovf_valid", io_diffValid, SNAP_EN);
    check("ovf_head_ds0", io_diff_dscratch0, 64'h0);
    io_diffReady = 1;
    repeat (DEPTH + 2) next_cycle();
    check("ovf_drained", io_diffValid, 0);

    // Single-step re-entry, then reset mid-DEBUG
    csr_write(12'h7B0, 64'h4);
    next_cycle();
    idle_inputs();
    io_dret = 1;
    next_cycle();
    io_dret = 0;
    next_cycle();
    io_stepDone = 1; io_pc = 64'h8000_4000; io_priv = 2'd1;
    next_cycle();
    io_stepDone = 0;
    check("step_dm", io_debugMode, 1);
    check("step_cause", io_dcsr[8:6], 64'd4);
    io_diffReady = 0;
    next_cycle();
    reset = 1;
    next_cycle();
    reset = 0;
    check("midrst_dm", io_debugMode, 0);
    check("midrst_valid", io_diffValid, 0);
    check("midrst_dcsr", io_dcsr, 64'h4000_0003);
    check("midrst_ovf", io_overflow, 0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      io_haltReq   = ($urandom_range(0, 9) == 0);
      io_ebreak    = ($urandom_range(0, 7) == 0);
      io_stepDone  = ($urandom_range(0, 3) == 0);
      io_dret      = ($urandom_range(0, 5) == 0);
      io_csrWen    = ($urandom_range(0, 1) == 0);
      io_csrAddr   = 12'h7B0 + 12'($urandom_range(0, 4));
      io_csrWdata  = {$urandom, $urandom};
      io_pc        = {$urandom, $urandom};
      io_priv      = 2'($urandom_range(0, 3));
      io_coreid    = 8'($urandom);
      io_diffReady = ($urandom_range(0, 2) != 0);
      reset        = ($urandom_range(0, 299) == 0);
      next_cycle();
    end
    reset = 0; idle_inputs(); io_diffReady = 1;
    repeat (DEPTH + 6) next_cycle();
    check("final_drained", io_diffValid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
